// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx
//  Description : Parallel-to-serial frame transmitter. Accepts a WIDTH-bit
//                word on a ready/load handshake and sends a start bit (0),
//                the data bits LSB first, then a stop bit (1). Each line bit
//                is held for CLKS_PER_BIT clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             busy,
    output logic             done
);

    localparam int c_BIT_W  = $clog2(WIDTH + 1);
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT + 1);

    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WIDTH - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_shift;
    logic [WIDTH-1:0]     w_shift_nxt;
    logic [WIDTH-1:0]     w_shift_sh;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_BIT_W-1:0]   w_bit_cnt_nxt;
    logic [c_BAUD_W-1:0]  r_baud_cnt;
    logic [c_BAUD_W-1:0]  w_baud_cnt_nxt;
    logic                 r_q;
    logic                 w_q_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_bit_end;

    // Handshake flags come straight from the state register.
    assign ready = (r_state == S_IDLE);
    assign busy  = ~ready;
    assign q     = r_q;
    assign done  = r_done;

    assign w_bit_end  = (r_baud_cnt == c_BAUD_LAST);
    assign w_shift_sh = r_shift >> 1;

    // State, datapath and registered line outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_q        <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_q        <= w_q_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state logic; q is computed for the state being entered so that the
    // registered line changes in the same cycle as the state.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_baud_cnt_nxt = r_baud_cnt;
        w_q_nxt        = 1'b1;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state_nxt    = S_START;
                    w_shift_nxt    = din;
                    w_bit_cnt_nxt  = '0;
                    w_baud_cnt_nxt = '0;
                    w_q_nxt        = 1'b0;
                end
            end

            S_START: begin
                w_q_nxt = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt    = S_DATA;
                    w_bit_cnt_nxt  = '0;
                    w_baud_cnt_nxt = '0;
                    w_q_nxt        = r_shift[0];
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + c_BAUD_W'(1);
                end
            end

            S_DATA: begin
                w_q_nxt = r_shift[0];
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    w_shift_nxt    = w_shift_sh;
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_state_nxt   = S_STOP;
                        w_bit_cnt_nxt = '0;
                        w_q_nxt       = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_BIT_W'(1);
                        w_q_nxt       = w_shift_sh[0];
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + c_BAUD_W'(1);
                end
            end

            S_STOP: begin
                w_q_nxt = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt    = S_IDLE;
                    w_baud_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                    w_done_nxt     = 1'b1;
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + c_BAUD_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx
//  Description : Self-checking bench for serial_tx. Two instances (8 bits at
//                4 clocks/bit, 4 bits at 1 clock/bit) are compared every cycle
//                against a frame-level model, plus vector tables and directed
//                corner-case sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din0;
    logic       load0;
    logic       ready0, q0, busy0, done0;
    logic [3:0] din1;
    logic       load1;
    logic       ready1, q1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut0 (
        .clk(clk), .rst(rst), .din(din0), .load(load0),
        .ready(ready0), .q(q0), .busy(busy0), .done(done0)
    );

    serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .load(load1),
        .ready(ready1), .q(q1), .busy(busy1), .done(done1)
    );

    // Frame-level model: k is the 1-based cycle number within the frame.
    typedef struct packed {
        logic        active;
        int          k;
        logic [31:0] word;
        logic        done;
    } mdl_t;

    mdl_t m0 = '0;
    mdl_t m1 = '0;

    function automatic mdl_t step(input mdl_t m, input logic r, input logic ld,
                                  input logic [31:0] d, input int w, input int c);
        mdl_t n = m;
        n.done = 1'b0;
        if (r) begin
            n.active = 1'b0;
            n.k      = 0;
        end else if (!m.active) begin
            if (ld) begin
                n.active = 1'b1;
                n.k      = 1;
                n.word   = d;
            end
        end else if (m.k == (w + 2) * c) begin
            n.active = 1'b0;
            n.done   = 1'b1;
        end else begin
            n.k = m.k + 1;
        end
        return n;
    endfunction

    function automatic logic exp_q(input mdl_t m, input int w, input int c);
        int j;
        if (!m.active) return 1'b1;
        j = (m.k - 1) / c;
        if (j == 0) return 1'b0;
        if (j <= w) return m.word[j-1];
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, stepping the model with the inputs seen at the edge.
    task automatic tick();
        m0 = step(m0, rst, load0, 32'(din0), 8, 4);
        m1 = step(m1, rst, load1, 32'(din1), 4, 1);
        @(posedge clk);
        #1;
        chk("m0_q",     q0,     exp_q(m0, 8, 4));
        chk("m0_busy",  busy0,  m0.active);
        chk("m0_ready", ready0, !m0.active);
        chk("m0_done",  done0,  m0.done);
        chk("m1_q",     q1,     exp_q(m1, 4, 1));
        chk("m1_busy",  busy1,  m1.active);
        chk("m1_ready", ready1, !m1.active);
        chk("m1_done",  done1,  m1.done);
    endtask

    task automatic accept(input logic [7:0] d);
        load0 = 1'b1;
        din0  = d;
        tick();
    endtask

    // Watch cycles 1..40 of a frame on dut0; slots[0] is the start bit,
    // slots[9] the stop bit. Ends in cycle 41.
    task automatic watch(input logic [9:0] slots, input int poke, input int hold_from);
        for (int k = 1; k <= 40; k++) begin
            chk("slot_q",     q0,    slots[(k-1)/4]);
            chk("frame_busy", busy0, 1'b1);
            chk("frame_done", done0, 1'b0);
            if (k == poke) begin
                load0 = 1'b1;
                din0  = 8'hFF;
            end else if (k >= hold_from) begin
                load0 = 1'b1;
                din0  = 8'h80;
            end else begin
                load0 = 1'b0;
                din0  = 8'($urandom);
            end
            tick();
        end
        chk("end_done",  done0,  1'b1);
        chk("end_ready", ready0, 1'b1);
        chk("end_q",     q0,     1'b1);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [9:0] slots;
        int         poke;
    } vec_t;

    vec_t vecs[4];
    logic [5:0] exp6;

    initial begin
        rst   = 1'b1;
        load0 = 1'b1;
        din0  = 8'hFF;
        load1 = 1'b1;
        din1  = 4'hF;

        // Reset held two cycles with load asserted.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_q",     q0,     1'b1);
            chk("rst_ready", ready0, 1'b1);
            chk("rst_busy",  busy0,  1'b0);
            chk("rst_done",  done0,  1'b0);
        end
        rst   = 1'b0;
        load0 = 1'b0;
        load1 = 1'b0;
        repeat (5) begin
            tick();
            chk("post_rst_q",     q0,     1'b1);
            chk("post_rst_ready", ready0, 1'b1);
        end

        // Table of single frames; the 3C entry pokes a rejected load at cycle 10.
        vecs[0] = '{8'hA5, 10'b11010_01010, 0};
        vecs[1] = '{8'h00, 10'b10000_00000, 0};
        vecs[2] = '{8'hFF, 10'b11111_11110, 0};
        vecs[3] = '{8'h3C, 10'b10011_11000, 10};
        for (int v = 0; v < 4; v++) begin
            accept(vecs[v].d);
            watch(vecs[v].slots, vecs[v].poke, 999);
            load0 = 1'b0;
            tick();
            chk("after_done", done0, 1'b0);
            chk("after_q",    q0,    1'b1);
        end

        // Back-to-back: 01, load held with 80 through the done cycle.
        accept(8'h01);
        watch(10'b10000_00010, 0, 30);
        tick();
        load0 = 1'b0;
        chk("b2b_start_q", q0,    1'b0);
        chk("b2b_busy",    busy0, 1'b1);
        watch(10'b11000_00000, 0, 999);
        tick();

        // Reset during cycle 17 of an A5 frame.
        accept(8'hA5);
        load0 = 1'b0;
        repeat (16) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_q",     q0,     1'b1);
        chk("abort_ready", ready0, 1'b1);
        chk("abort_busy",  busy0,  1'b0);
        for (int i = 0; i < 50; i++) begin
            chk("abort_no_done", done0, 1'b0);
            chk("abort_idle_q",  q0,    1'b1);
            tick();
        end
        accept(8'h5A);
        watch(10'b10101_10100, 0, 999);
        load0 = 1'b0;
        tick();

        // One clock per bit, 4-bit word 1011.
        load1 = 1'b1;
        din1  = 4'b1011;
        tick();
        load1 = 1'b0;
        exp6  = 6'b110110;
        for (int k = 0; k < 6; k++) begin
            chk("fast_q",    q1,    exp6[k]);
            chk("fast_busy", busy1, 1'b1);
            chk("fast_done", done1, 1'b0);
            tick();
        end
        chk("fast_end_done",  done1,  1'b1);
        chk("fast_end_ready", ready1, 1'b1);
        tick();
        chk("fast_done_clear", done1, 1'b0);

        // Random traffic against the model on both instances.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            load0 = ($urandom_range(0, 3) == 0);
            din0  = 8'($urandom);
            load1 = ($urandom_range(0, 2) == 0);
            din1  = 4'($urandom);
            tick();
        end
        rst   = 1'b0;
        load0 = 1'b0;
        load1 = 1'b0;
        repeat (50) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
